// File: rtl/path_pkg.sv
// rtl/path_pkg.sv - shared constants, arbiter state type and clog2 helper for the path arbiter
package path_pkg;

    localparam int PATH_N         = 4;
    localparam int PATH_DWIDTH    = 8;
    localparam int PATH_MAX_BURST = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/path_rr_pick.sv
// rtl/path_rr_pick.sv - combinational cyclic first-requester search starting at ptr
module path_rr_pick
    import path_pkg::*;
#(
    parameter  int N    = PATH_N,
    localparam int IDXW = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    // Walk offsets 0..N-1 from ptr; the smallest offset with a request wins.
    always_comb begin
        int j;
        logic [IDXW-1:0] jj;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        jj    = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            jj = IDXW'(j);
            if (!found && req[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
    end

endmodule

// File: rtl/path_arbiter.sv
// rtl/path_arbiter.sv - round-robin burst-limited arbiter and output mux for N path requesters
module path_arbiter
    import path_pkg::*;
#(
    parameter  int N         = PATH_N,
    parameter  int DWIDTH    = PATH_DWIDTH,
    parameter  int MAX_BURST = PATH_MAX_BURST,
    localparam int IDXW      = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req_i,
    input  logic [N-1:0]          valid_i,
    input  logic [N*DWIDTH-1:0]   data_i,
    output logic [N-1:0]          gnt_o,
    output logic [DWIDTH-1:0]     data_o,
    output logic                  valid_o,
    output logic [IDXW-1:0]       owner_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int CW = clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    arb_state_e        state_q, state_d;
    logic [N-1:0]      gnt_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IDXW-1:0]   sel_q;
    logic              sel_v_q;

    logic [IDXW-1:0]   owner_inc;
    logic              hold;
    logic              rel;
    logic [IDXW-1:0]   pick_ptr;
    logic              pick_found;
    logic [IDXW-1:0]   pick_idx;

    logic [DWIDTH-1:0] data_arr [N];
    logic [N-1:0]      sel_mask;
    logic              take;
    logic              stray;

    assign owner_inc = (owner_q == IDXW'(N - 1)) ? '0 : owner_q + IDXW'(1);
    assign hold      = req_i[owner_q] && (cnt_q < CNT_MAX);
    assign rel       = (state_q == BUSY) && !hold;
    // On release the search starts just past the old owner so it is considered last.
    assign pick_ptr  = rel ? owner_inc : ptr_q;

    path_rr_pick #(.N(N)) u_pick (
        .req   (req_i),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Arbitration state, grant, owner, burst counter and rotation pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_o   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_o   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next grant: grab a winner from idle, extend the burst, or hand over without a gap.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_o;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    gnt_d   = N'(1) << pick_idx;
                    owner_d = pick_idx;
                    cnt_d   = CW'(1);
                end
            end
            BUSY: begin
                if (!rel) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    ptr_d = owner_inc;
                    if (pick_found) begin
                        gnt_d   = N'(1) << pick_idx;
                        owner_d = pick_idx;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        owner_d = '0;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                owner_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    for (genvar k = 0; k < N; k++) begin : g_slice
        assign data_arr[k] = data_i[k*DWIDTH +: DWIDTH];
    end

    // A path answers one cycle after seeing its grant, so the mux select lags the grant by one.
    assign sel_mask = sel_v_q ? (N'(1) << sel_q) : '0;
    assign take     = sel_v_q & valid_i[sel_q];
    assign stray    = |(valid_i & ~sel_mask);

    // Output mux register plus sticky flag for valid from a path that does not own the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            sel_v_q <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
            err_o   <= 1'b0;
        end else begin
            sel_q   <= owner_q;
            sel_v_q <= |gnt_o;
            valid_o <= take;
            if (take) begin
                data_o <= data_arr[sel_q];
            end
            if (stray) begin
                err_o <= 1'b1;
            end
        end
    end

    assign owner_o = owner_q;
    assign busy_o  = |gnt_o;

endmodule

// File: tb/tb_path_arbiter.sv
// tb/tb_path_arbiter.sv - randomized and directed checks of path_arbiter against a behavioural model
module tb_path_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_i;
    logic [N-1:0]    valid_i;
    logic [N*DW-1:0] data_i;
    logic [N-1:0]    gnt_o;
    logic [DW-1:0]   data_o;
    logic            valid_o;
    logic [1:0]      owner_o;
    logic            busy_o;
    logic            err_o;

    int tests = 0;
    int fails = 0;

    bit            m_busy;
    int            m_owner;
    int            m_cnt;
    int            m_ptr;
    int            m_sel;
    bit            m_selv;
    bit            m_valid;
    bit            m_err;
    logic [DW-1:0] m_data;

    path_arbiter #(.N(N), .DWIDTH(DW), .MAX_BURST(MB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .gnt_o   (gnt_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .owner_o (owner_o),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] slice(input int k);
        return DW'(data_i >> (k * DW));
    endfunction

    function automatic logic [N-1:0] m_gnt();
        return m_busy ? N'(1 << m_owner) : '0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_sel = 0;
        m_selv = 0; m_valid = 0; m_err = 0; m_data = '0;
    endtask

    task automatic model_step();
        int  w;
        bit  n_valid;
        n_valid = m_selv && valid_i[m_sel];
        if (n_valid) m_data = slice(m_sel);
        for (int j = 0; j < N; j++) begin
            if (valid_i[j] && !(m_selv && j == m_sel)) m_err = 1;
        end
        m_valid = n_valid;
        m_selv  = m_busy;
        m_sel   = m_owner;
        if (!m_busy) begin
            w = pick(req_i, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_cnt = 1;
            end
        end else if (req_i[m_owner] && m_cnt < MB) begin
            m_cnt = m_cnt + 1;
        end else begin
            m_ptr = (m_owner + 1) % N;
            w = pick(req_i, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_cnt = 1;
            end else begin
                m_busy = 0; m_owner = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".gnt"},   32'(gnt_o),   32'(m_gnt()));
        check({tag, ".owner"}, 32'(owner_o), 32'(m_owner));
        check({tag, ".busy"},  32'(busy_o),  32'(m_busy));
        check({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
        check({tag, ".data"},  32'(data_o),  32'(m_data));
        check({tag, ".err"},   32'(err_o),   32'(m_err));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int len;
        logic [N-1:0] pat;

        rst_n = 1'b0; req_i = '0; valid_i = '0; data_i = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        req_i = 4'b1111;
        for (int i = 1; i <= 50; i++) begin
            tick("rr");
            check("rr.seq", 32'(gnt_o), 32'(1 << (((i - 1) / 10) % 4)));
        end
        req_i = '0;
        tick("rr_drop");
        tick("rr_idle");

        req_i = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick("single");
            check("single.gnt", 32'(gnt_o), 32'h4);
            check("single.owner", 32'(owner_o), 32'd2);
        end
        req_i = '0;
        tick("single_drop");
        check("single.release", 32'(gnt_o), 32'h0);
        tick("single_idle");

        req_i = 4'b0001;
        for (int i = 1; i <= 25; i++) begin
            tick("sole");
            check("sole.gnt", 32'(gnt_o), 32'h1);
        end
        req_i = 4'b0011;
        for (int i = 26; i <= 30; i++) begin
            tick("wrap");
            check("wrap.gnt", 32'(gnt_o), 32'h1);
        end
        tick("wrap_move");
        check("wrap.handover", 32'(gnt_o), 32'h2);
        req_i = '0;
        tick("wrap_drop");
        tick("wrap_idle");

        for (int s = 0; s < 40; s++) begin
            pat = N'($urandom_range(0, 15));
            len = $urandom_range(1, 25);
            req_i = pat;
            for (int c = 0; c < len; c++) begin
                valid_i = (m_selv && $urandom_range(0, 1) == 1) ? N'(1 << m_sel) : '0;
                data_i  = $urandom;
                tick("rand");
            end
        end
        req_i = '0; valid_i = '0;
        for (int i = 0; i < 3; i++) tick("rand_drain");

        req_i = 4'b0010;
        tick("dp_grant");
        check("dp.gnt", 32'(gnt_o), 32'h2);
        tick("dp_sel");
        valid_i = 4'b0010;
        data_i  = 32'h3C00_A500;
        tick("dp_beat");
        check("dp.valid", 32'(valid_o), 32'h1);
        check("dp.data", 32'(data_o), 32'hA5);
        valid_i = '0;
        tick("dp_gap");
        check("dp.gap_valid", 32'(valid_o), 32'h0);
        check("dp.hold_data", 32'(data_o), 32'hA5);
        valid_i = 4'b1000;
        tick("err_set");
        check("err.flag", 32'(err_o), 32'h1);
        check("err.data", 32'(data_o), 32'hA5);
        valid_i = '0;
        tick("err_sticky");
        check("err.sticky", 32'(err_o), 32'h1);

        req_i = '0;
        tick("rst_prep0");
        tick("rst_prep1");
        req_i = 4'b0100;
        tick("burst1");
        tick("burst2");
        valid_i = 4'b0100;
        data_i  = 32'h0077_0000;
        tick("burst3");
        tick("burst4");
        tick("burst5");
        check("pre_rst.valid", 32'(valid_o), 32'h1);
        check("pre_rst.owner", 32'(owner_o), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async.gnt", 32'(gnt_o), 32'h0);
        check("async.valid", 32'(valid_o), 32'h0);
        check("async.err", 32'(err_o), 32'h0);
        check("async.busy", 32'(busy_o), 32'h0);
        check_all("async");
        valid_i = '0;
        req_i   = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        tick("restart");
        check("restart.gnt", 32'(gnt_o), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
